// File: rtl/rv32_bus_pkg.sv
// Shared address map and UART state encoding for the rv32 memory-bus responder.
package rv32_bus_pkg;

    localparam logic [31:0] ADDR_LED      = 32'h8000_0000;
    localparam logic [31:0] ADDR_UART     = 32'h8000_0004;
    localparam logic [31:0] ADDR_CYCLE_LO = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYCLE_HI = 32'h8000_000C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/rv32_uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit,
// UART_DIV clock cycles per bit. busy_out and tx_out come straight from flops.
module rv32_uart_tx
    import rv32_bus_pkg::*;
#(
    parameter int UART_DIV = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_in,
    input  logic [7:0] data_in,
    output logic       busy_out,
    output logic       tx_out
);

    localparam int             DW       = $clog2(UART_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(UART_DIV - 1);

    uart_state_t   state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    data_q;
    logic          div_done;
    logic [2:0]    bit_next;

    assign div_done = (div_q == DIV_LAST);
    assign bit_next = bit_q + 3'd1;

    // tx_out is loaded one edge ahead of each bit so the line changes exactly
    // on the bit boundary; reset forces it high mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            busy_out <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_q  <= START;
                        data_q   <= data_in;
                        div_q    <= '0;
                        bit_q    <= '0;
                        busy_out <= 1'b1;
                        tx_out   <= 1'b0;
                    end
                end
                START: begin
                    if (div_done) begin
                        state_q <= DATA;
                        div_q   <= '0;
                        tx_out  <= data_q[0];
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                DATA: begin
                    if (div_done) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            bit_q   <= '0;
                            tx_out  <= 1'b1;
                        end else begin
                            bit_q  <= bit_next;
                            tx_out <= data_q[bit_next];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                STOP: begin
                    if (div_done) begin
                        state_q  <= IDLE;
                        div_q    <= '0;
                        busy_out <= 1'b0;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rv32_bus.sv
// Slave end of the rv32 single-cycle data bus: RAM, LED register, UART and a
// 64-bit cycle counter. Reads are combinational; writes commit on the edge.
module rv32_bus
    import rv32_bus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int UART_DIV  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        uart_tx_out,
    output logic [7:0]  leds_out
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [63:0]   cycle_q;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          led_sel;
    logic          uart_sel;
    logic          cyc_lo_sel;
    logic          cyc_hi_sel;
    logic          uart_busy;
    logic          uart_start;
    logic          unused_addr_bits;

    // Byte-offset bits never take part in decode.
    assign unused_addr_bits = ^address_in[1:0];

    assign ram_idx    = address_in[AW+1:2];
    assign ram_hit    = (address_in[31:AW+2] == '0);
    assign led_sel    = (address_in[31:2] == ADDR_LED[31:2]);
    assign uart_sel   = (address_in[31:2] == ADDR_UART[31:2]);
    assign cyc_lo_sel = (address_in[31:2] == ADDR_CYCLE_LO[31:2]);
    assign cyc_hi_sel = (address_in[31:2] == ADDR_CYCLE_HI[31:2]);
    assign uart_start = uart_sel && write_mask_in[0] && !uart_busy;

    always_ff @(posedge clk) begin
        if (ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (write_mask_in[i]) begin
                    mem[ram_idx][8*i +: 8] <= write_value_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds_out <= '0;
        end else if (led_sel && write_mask_in[0]) begin
            leds_out <= write_value_in[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    rv32_uart_tx #(
        .UART_DIV (UART_DIV)
    ) u_uart_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_in (uart_start),
        .data_in  (write_value_in[7:0]),
        .busy_out (uart_busy),
        .tx_out   (uart_tx_out)
    );

    always_comb begin
        read_value_out = '0;
        if (ram_hit) begin
            read_value_out = mem[ram_idx];
        end else if (led_sel) begin
            read_value_out = {24'b0, leds_out};
        end else if (uart_sel) begin
            read_value_out = {31'b0, uart_busy};
        end else if (cyc_lo_sel) begin
            read_value_out = cycle_q[31:0];
        end else if (cyc_hi_sel) begin
            read_value_out = cycle_q[63:32];
        end
    end

endmodule

// File: tb/tb_rv32_bus.sv
// Directed bench for rv32_bus: the driver queues expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_rv32_bus;
  import rv32_bus_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int UART_DIV  = 4;
  localparam int FRAME     = 10 * UART_DIV;
  localparam int SEL_READ  = 0;
  localparam int SEL_TX    = 1;
  localparam int SEL_LEDS  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        uart_tx_out;
  logic [7:0]  leds_out;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_cyc;

  always #5 clk = ~clk;

  rv32_bus #(
    .MEM_WORDS (MEM_WORDS),
    .UART_DIV  (UART_DIV)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .read_value_out (read_value_out),
    .uart_tx_out    (uart_tx_out),
    .leds_out       (leds_out)
  );

  // Reference cycle count: zero while in reset, +1 per edge afterwards.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_cyc <= '0;
    else          m_cyc <= m_cyc + 64'd1;
  end

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          s;
      string       t;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      case (s)
        SEL_TX:   a = {31'b0, uart_tx_out};
        SEL_LEDS: a = {24'b0, leds_out};
        default:  a = read_value_out;
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end

  function automatic void expect_out(input int sel, input logic [31:0] v, input string tag);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    address_in    = a;
    write_mask_in = 4'b0000;
    expect_out(SEL_READ, e, tag);
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] v);
    address_in     = a;
    write_mask_in  = m;
    write_value_in = v;
    step();
    write_mask_in  = 4'b0000;
  endtask

  // Starts a frame of d, optionally writes mid_d at cycle mid_j, and always
  // tries a write in the last STOP cycle, which must be dropped.
  task automatic uart_frame(input logic [7:0] d, input int mid_j, input logic [7:0] mid_d);
    address_in     = ADDR_UART;
    write_mask_in  = 4'b0001;
    write_value_in = {24'h0, d};
    expect_out(SEL_READ, 32'd0, "uart busy before start");
    expect_out(SEL_TX, 32'd1, "uart tx before start");
    step();
    for (int j = 1; j <= FRAME + 1; j++) begin
      logic exp_tx;
      int   seg;
      seg = (j - 1) / UART_DIV;
      if (j > FRAME)      exp_tx = 1'b1;
      else if (seg == 0)  exp_tx = 1'b0;
      else if (seg == 9)  exp_tx = 1'b1;
      else                exp_tx = d[seg-1];
      write_mask_in  = (j == mid_j || j == FRAME) ? 4'b0001 : 4'b0000;
      write_value_in = (j == mid_j) ? {24'h0, mid_d} : 32'h0;
      expect_out(SEL_TX, {31'b0, exp_tx}, $sformatf("uart tx cycle %0d", j));
      expect_out(SEL_READ, (j <= FRAME) ? 32'd1 : 32'd0, $sformatf("uart busy cycle %0d", j));
      step();
    end
    write_mask_in = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    address_in     = ADDR_CYCLE_LO;
    write_mask_in  = 4'b0000;
    write_value_in = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    checks++;
    if (uart_tx_out !== 1'b1) begin
      errors++;
      $display("FAIL direct reset tx: got %b expected 1", uart_tx_out);
    end
    checks++;
    if (leds_out !== 8'h00) begin
      errors++;
      $display("FAIL direct reset leds: got %h expected 00", leds_out);
    end

    expect_out(SEL_TX, 32'd1, "reset tx");
    expect_out(SEL_LEDS, 32'd0, "reset leds");
    rd(ADDR_CYCLE_LO, 32'd0, "reset cycle_lo");
    rd(ADDR_LED, 32'd0, "reset led reg");
    rd(ADDR_UART, 32'd0, "reset uart busy");

    wr(32'h10, 4'b1111, 32'hDEAD_BEEF);
    address_in     = 32'h10;
    write_mask_in  = 4'b0010;
    write_value_in = 32'h0000_5500;
    expect_out(SEL_READ, 32'hDEAD_BEEF, "ram old value in write cycle");
    step();
    write_mask_in = 4'b0000;
    rd(32'h10, 32'hDEAD_55EF, "ram masked write");
    rd(32'h13, 32'hDEAD_55EF, "ram byte offset ignored");
    rd(MEM_WORDS * 4, 32'h0, "ram end unmapped");
    wr(MEM_WORDS * 4 + 32'h10, 4'b1111, 32'h1111_1111);
    rd(32'h10, 32'hDEAD_55EF, "ram alias write ignored");

    wr(ADDR_LED, 4'b0001, 32'h1234_56A5);
    expect_out(SEL_LEDS, 32'hA5, "led write lane0");
    rd(ADDR_LED, 32'hA5, "led readback");
    wr(ADDR_LED, 4'b1110, 32'hFFFF_FF00);
    expect_out(SEL_LEDS, 32'hA5, "led upper lanes ignored");
    rd(ADDR_LED | 32'h3, 32'hA5, "led byte offset ignored");
    rd(32'h8000_0010, 32'h0, "unmapped peripheral");

    rd(ADDR_CYCLE_LO, m_cyc[31:0], "cycle lo first");
    rd(ADDR_CYCLE_LO, m_cyc[31:0], "cycle lo next");
    rd(ADDR_CYCLE_HI, m_cyc[63:32], "cycle hi");
    wr(ADDR_CYCLE_LO, 4'b1111, 32'h1234_5678);
    rd(ADDR_CYCLE_LO, m_cyc[31:0], "cycle lo write ignored");

    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    step();
    rd(ADDR_CYCLE_LO, 32'h0, "cycle lo wrap");
    rd(ADDR_CYCLE_HI, 32'h1, "cycle hi carry");

    uart_frame(8'h5A, 20, 8'hFF);

    address_in     = ADDR_UART;
    write_mask_in  = 4'b0001;
    write_value_in = 32'h0;
    step();
    write_mask_in = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) expect_out(SEL_TX, 32'd0, "tx low before reset");
      step();
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (uart_tx_out !== 1'b1) begin
      errors++;
      $display("FAIL direct async reset tx: got %b expected 1", uart_tx_out);
    end
    checks++;
    if (leds_out !== 8'h00) begin
      errors++;
      $display("FAIL direct async reset leds: got %h expected 00", leds_out);
    end
    expect_out(SEL_TX, 32'd1, "tx high on async reset");
    expect_out(SEL_READ, 32'd0, "busy clear on async reset");
    expect_out(SEL_LEDS, 32'd0, "leds clear on async reset");
    step();
    reset_n = 1'b1;
    step();
    uart_frame(8'hA3, 0, 8'h00);

    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never checked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule
